divider_arbiter: RTL and testbench
==================================

DIVIDER_ARBITER -- requirements
Module: divider_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requesters.
REQ-002 The block SHALL have parameter W, default 16, giving the divider config width.
REQ-003 The block SHALL have parameter LEASE, default 8, giving the output periods per grant.
REQ-004 The block SHALL have parameter IDLE_TOTAL, default 2, giving the total_cycles value driven when no grant is held.
REQ-005 The block SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port req, input, NREQ bits: per-requester level request.
REQ-008 The block SHALL have port req_total, input, NREQ*W bits: packed per-requester period; slice i belongs to requester i.
REQ-009 The block SHALL have port req_high, input, NREQ*W bits: packed per-requester high time.
REQ-010 The block SHALL have port grant, output, NREQ bits: one-hot or zero owner of the divider.
REQ-011 The block SHALL have port busy, output, 1 bit: high in states LOAD, RUN and RELEASE.
REQ-012 The block SHALL have port total_cycles, output, W bits: config to the divider.
REQ-013 The block SHALL have port high_cycles, output, W bits: config to the divider.
REQ-014 The block SHALL have port period_done, output, 1 bit: one-cycle pulse on the last cycle of each RUN period.

Function
REQ-015 The FSM SHALL have exactly the states IDLE, LOAD, RUN and RELEASE, and all outputs SHALL be registered.
REQ-016 In IDLE with req!=0, the block SHALL pick a winner round-robin, starting at the index after the last winner, and register grant (one-hot) and state=LOAD on the next edge.
REQ-017 In LOAD, for one cycle, the block SHALL latch the winner's config: total = max(req_total,1); high = min(req_high, total).
REQ-018 The block SHALL drive total_cycles and high_cycles from the latched values from LOAD through the end of RUN.
REQ-019 In RUN, the period counter SHALL count 0..total-1 and wrap; period_done SHALL be 1 when counter==total-1.
REQ-020 The lease counter SHALL increment on each period_done; on the period_done at which the lease count reaches LEASE, the next state SHALL be RELEASE.
REQ-021 If the granted req drops during RUN, the block SHALL finish the current period and then go to RELEASE; there is no mid-period truncation.
REQ-022 In RELEASE, for one cycle, the block SHALL hold grant=0, set total_cycles=IDLE_TOTAL and high_cycles=0, and update the round-robin pointer to the winner.
REQ-023 From RELEASE, the next state SHALL be LOAD with a new grant if req!=0 (same arbitration rule as REQ-016), else IDLE.
REQ-024 The request-to-grant latency SHALL be 1 cycle from IDLE; grant to first RUN cycle SHALL be 1 cycle.
REQ-025 Changes to req_total or req_high after LOAD SHALL be ignored until the next grant.
REQ-026 Requests from non-granted requesters SHALL never preempt the current owner.
REQ-027 The lease counter SHALL be wide enough for LEASE, and the period counter SHALL be W bits with no overflow for total up to 2^W-1.
REQ-028 Outside LOAD and RUN, total_cycles SHALL equal IDLE_TOTAL and high_cycles SHALL equal 0, so the divider output is held low.

Reset
REQ-029 With rst_n=0 at an edge: state=IDLE, grant=0, busy=0, period_done=0, total_cycles=IDLE_TOTAL, high_cycles=0, counters=0, round-robin pointer=NREQ-1 (so requester 0 has first priority).
REQ-030 Reset asserted mid-RUN SHALL abort the lease immediately with no RELEASE cycle, and the first post-reset grant SHALL obey REQ-029 priority.

Structure
REQ-031 Package divider_arb_pkg SHALL hold the state enum, the W and IDLE_TOTAL defaults, and the sanitize rule constants.
REQ-032 The round-robin pick SHALL be a sub-module rr_arbiter (inputs: req, last-winner pointer; output: one-hot pick plus index), combinational; the FSM and counters SHALL stay in divider_arbiter.

Verification
REQ-033 Single requester: req=0001, total=5, high=2, LEASE=8 -> grant=0001 one cycle later, 8 period_done pulses 5 cycles apart, RELEASE, then IDLE with total_cycles=2 and high_cycles=0.
REQ-034 Fairness: req=1111 held -> grant order 0001, 0010, 0100, 1000, 0001, with exactly one RELEASE cycle between owners.
REQ-035 Early drop: owner drops req on counter=1 of period 3 (total=4) -> RELEASE after that period's period_done, with no further periods.
REQ-036 Sanitize: req_total=0, req_high=7 -> total_cycles=1, high_cycles=1; req_total=6, req_high=9 -> total_cycles=6, high_cycles=6.
REQ-037 Reset mid-RUN (owner 2) -> next edge grant=0 and busy=0; with req=0110 after reset, grant=0010.
REQ-038 Config change: alter req_total during RUN -> total_cycles unchanged until the next LOAD.

Source files
------------

// File: rtl/divider_arb_pkg.sv
// Shared types and constants for the divider arbiter slice.
package divider_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        RUN     = 2'd2,
        RELEASE = 2'd3
    } state_t;

    localparam int DEF_NREQ       = 4;
    localparam int DEF_W          = 16;
    localparam int DEF_LEASE      = 8;
    localparam int DEF_IDLE_TOTAL = 2;

    // Config sanitising: a period of zero is promoted to the shortest legal
    // period, and the high time is clamped to the period.
    localparam int MIN_TOTAL = 1;
    // High time driven while nobody owns the divider keeps its output low.
    localparam int IDLE_HIGH = 0;

endpackage

// File: rtl/divider_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first active requester after the last winner.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   pick_idx
);

    logic [IW-1:0] idx;
    logic          found;

    // Walk the requesters starting one past the last winner, wrapping around
    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (!found && req[idx]) begin
                found     = 1'b1;
                pick[idx] = 1'b1;
                pick_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/divider_arbiter.sv
// Leases a shared clock divider to one of NREQ requesters for LEASE output periods.
module divider_arbiter
    import divider_arb_pkg::*;
#(
    parameter int NREQ       = DEF_NREQ,
    parameter int W          = DEF_W,
    parameter int LEASE      = DEF_LEASE,
    parameter int IDLE_TOTAL = DEF_IDLE_TOTAL
) (
    input  logic              clk_in,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_total,
    input  logic [NREQ*W-1:0] req_high,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [W-1:0]      total_cycles,
    output logic [W-1:0]      high_cycles,
    output logic              period_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int LW = $clog2(LEASE + 1);

    state_t        state, state_n;
    logic [IW-1:0] owner, owner_n;
    logic [IW-1:0] ptr, ptr_n;
    logic [W-1:0]  cnt, cnt_n;
    logic [LW-1:0] lease_cnt, lease_n;
    logic          dropped, dropped_n;

    logic [NREQ-1:0] grant_n;
    logic            busy_n;
    logic [W-1:0]    total_n;
    logic [W-1:0]    high_n;
    logic            pd_n;

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            any_req;
    logic [W-1:0]    cand_total;
    logic [W-1:0]    cand_high;
    logic [W-1:0]    san_total;
    logic [W-1:0]    san_high;
    logic            period_end;
    logic            drop_now;

    rr_arbiter #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr (
        .req      (req),
        .last     (ptr),
        .pick     (pick),
        .pick_idx (pick_idx)
    );

    assign any_req    = |req;
    assign cand_total = req_total[pick_idx*W +: W];
    assign cand_high  = req_high[pick_idx*W +: W];
    assign san_total  = (cand_total < W'(MIN_TOTAL)) ? W'(MIN_TOTAL) : cand_total;
    assign san_high   = (cand_high > san_total) ? san_total : cand_high;
    assign period_end = (cnt == total_cycles - W'(1));
    assign drop_now   = dropped | ~req[owner];

    // Next-state, counter and output decode; every output is registered from these values
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        ptr_n     = ptr;
        cnt_n     = cnt;
        lease_n   = lease_cnt;
        dropped_n = dropped;
        grant_n   = grant;
        busy_n    = busy;
        total_n   = total_cycles;
        high_n    = high_cycles;
        pd_n      = 1'b0;
        case (state)
            IDLE, RELEASE: begin
                if (any_req) begin
                    state_n = LOAD;
                    grant_n = pick;
                    owner_n = pick_idx;
                    busy_n  = 1'b1;
                    total_n = san_total;
                    high_n  = san_high;
                end else if (state == RELEASE) begin
                    state_n = IDLE;
                    busy_n  = 1'b0;
                end
            end
            LOAD: begin
                state_n   = RUN;
                cnt_n     = '0;
                lease_n   = '0;
                dropped_n = 1'b0;
                pd_n      = (total_cycles == W'(1));
            end
            RUN: begin
                dropped_n = drop_now;
                if (period_end) begin
                    lease_n = lease_cnt + LW'(1);
                    cnt_n   = '0;
                    if ((lease_n == LW'(LEASE)) || drop_now) begin
                        state_n = RELEASE;
                        grant_n = '0;
                        total_n = W'(IDLE_TOTAL);
                        high_n  = W'(IDLE_HIGH);
                        ptr_n   = owner;
                    end else begin
                        pd_n = (total_cycles == W'(1));
                    end
                end else begin
                    cnt_n = cnt + W'(1);
                    pd_n  = (cnt_n == total_cycles - W'(1));
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; reset abandons any lease on the spot
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state        <= IDLE;
            owner        <= '0;
            ptr          <= IW'(NREQ - 1);
            cnt          <= '0;
            lease_cnt    <= '0;
            dropped      <= 1'b0;
            grant        <= '0;
            busy         <= 1'b0;
            total_cycles <= W'(IDLE_TOTAL);
            high_cycles  <= W'(IDLE_HIGH);
            period_done  <= 1'b0;
        end else begin
            state        <= state_n;
            owner        <= owner_n;
            ptr          <= ptr_n;
            cnt          <= cnt_n;
            lease_cnt    <= lease_n;
            dropped      <= dropped_n;
            grant        <= grant_n;
            busy         <= busy_n;
            total_cycles <= total_n;
            high_cycles  <= high_n;
            period_done  <= pd_n;
        end
    end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed scenarios plus random traffic against a timeline model.
module tb_divider_arbiter;

    localparam int NREQ       = 4;
    localparam int W          = 16;
    localparam int LEASE      = 8;
    localparam int IDLE_TOTAL = 2;

    logic              clk_in;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_total;
    logic [NREQ*W-1:0] req_high;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [W-1:0]      total_cycles;
    logic [W-1:0]      high_cycles;
    logic              period_done;

    int total_checks = 0;
    int bad_checks   = 0;

    // Model: a lease is described by its start, its period T and how many periods it gets.
    // m_rel counts cycles since the grant: 0 = load, 1..n*T = periods, n*T+1 = release.
    int m_owner;
    int m_last;
    int m_rel;
    int m_n;
    int m_T;
    int m_H;
    bit m_dropped;

    int              pd_seen;
    int              rel_seen;
    int              pd_gap;
    int              last_pd_cycle;
    int              cycle_no;
    logic [NREQ-1:0] prev_grant;
    logic [NREQ-1:0] grant_log[$];

    divider_arbiter #(
        .NREQ       (NREQ),
        .W          (W),
        .LEASE      (LEASE),
        .IDLE_TOTAL (IDLE_TOTAL)
    ) dut (
        .clk_in       (clk_in),
        .rst_n        (rst_n),
        .req          (req),
        .req_total    (req_total),
        .req_high     (req_high),
        .grant        (grant),
        .busy         (busy),
        .total_cycles (total_cycles),
        .high_cycles  (high_cycles),
        .period_done  (period_done)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        if (observed !== expected) begin
            bad_checks++;
            $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] r, input int last);
        for (int k = 1; k <= NREQ; k++) begin
            if (r[(last + k) % NREQ]) return (last + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic start_grant(input int w);
        int t;
        int h;
        t = int'(req_total[w*W +: W]);
        h = int'(req_high[w*W +: W]);
        m_owner   = w;
        m_rel     = 0;
        m_dropped = 1'b0;
        m_n       = LEASE;
        m_T       = (t < 1) ? 1 : t;
        m_H       = (h > m_T) ? m_T : h;
    endtask

    // Advance the model across one clock edge using the inputs currently driven
    task automatic model_advance();
        int w;
        int p;
        if (!rst_n) begin
            m_owner = -1;
            m_last  = NREQ - 1;
        end else if (m_owner < 0) begin
            w = rr_pick(req, m_last);
            if (w >= 0) start_grant(w);
        end else if (m_rel == m_n * m_T + 1) begin
            m_last = m_owner;
            w = rr_pick(req, m_last);
            if (w >= 0) start_grant(w);
            else m_owner = -1;
        end else begin
            if (m_rel >= 1 && !m_dropped && !req[m_owner]) begin
                m_dropped = 1'b1;
                p = (m_rel + m_T - 1) / m_T;
                m_n = (p < LEASE) ? p : LEASE;
            end
            m_rel++;
        end
    endtask

    task automatic compare_all();
        logic [NREQ-1:0] eg;
        logic            eb;
        int              et;
        int              eh;
        logic            ep;
        eg = '0; eb = 1'b0; et = IDLE_TOTAL; eh = 0; ep = 1'b0;
        if (m_owner >= 0) begin
            eb = 1'b1;
            if (m_rel != m_n * m_T + 1) begin
                eg = '0;
                eg[m_owner] = 1'b1;
                et = m_T;
                eh = m_H;
                ep = (m_rel >= 1) && (m_rel % m_T == 0);
            end
        end
        checkOutput("grant", grant, eg);
        checkOutput("busy", busy, eb);
        checkOutput("total_cycles", total_cycles, et);
        checkOutput("high_cycles", high_cycles, eh);
        checkOutput("period_done", period_done, ep);
        cycle_no++;
        if (period_done === 1'b1) begin
            pd_seen++;
            pd_gap = cycle_no - last_pd_cycle;
            last_pd_cycle = cycle_no;
        end
        if (busy === 1'b1 && grant === '0) rel_seen++;
        if (grant !== prev_grant && grant !== '0) grant_log.push_back(grant);
        prev_grant = grant;
    endtask

    task automatic applyStimulus(input logic [NREQ-1:0] r, input logic rn);
        req   = r;
        rst_n = rn;
        model_advance();
        @(posedge clk_in);
        @(negedge clk_in);
        compare_all();
    endtask

    task automatic set_cfg(input int i, input int t, input int h);
        req_total[i*W +: W] = W'(t);
        req_high[i*W +: W]  = W'(h);
    endtask

    task automatic clear_obs();
        pd_seen = 0;
        rel_seen = 0;
        pd_gap = 0;
        last_pd_cycle = cycle_no;
        grant_log.delete();
    endtask

    task automatic do_reset();
        applyStimulus('0, 1'b0);
        applyStimulus('0, 1'b0);
        clear_obs();
    endtask

    task automatic flush(input int n);
        for (int k = 0; k < n; k++) applyStimulus('0, 1'b1);
    endtask

    // Directed scenarios first, then random traffic with occasional resets
    initial begin
        logic [NREQ-1:0] order[5];
        logic [NREQ-1:0] r;
        rst_n = 1'b0; req = '0; req_total = '0; req_high = '0;
        m_owner = -1; m_last = NREQ - 1; m_rel = 0; m_n = LEASE; m_T = 1; m_H = 0; m_dropped = 1'b0;
        cycle_no = 0; prev_grant = '0;
        clear_obs();
        @(negedge clk_in);

        // reset state
        do_reset();
        checkOutput("rst_total", total_cycles, IDLE_TOTAL);
        checkOutput("rst_busy", busy, 0);

        // single requester, full lease
        set_cfg(0, 5, 2);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t1_grant", grant, 4'b0001);
        for (int k = 1; k <= 50; k++) applyStimulus((k <= 40) ? 4'b0001 : 4'b0000, 1'b1);
        checkOutput("t1_pulses", pd_seen, 8);
        checkOutput("t1_gap", pd_gap, 5);
        checkOutput("t1_release", rel_seen, 1);
        checkOutput("t1_idle_total", total_cycles, 2);
        checkOutput("t1_idle_high", high_cycles, 0);
        checkOutput("t1_busy", busy, 0);

        // fairness with everyone requesting
        do_reset();
        for (int i = 0; i < NREQ; i++) set_cfg(i, 1, 1);
        for (int k = 0; k <= 45; k++) applyStimulus(4'b1111, 1'b1);
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b0100; order[3] = 4'b1000; order[4] = 4'b0001;
        checkOutput("t2_count", grant_log.size(), 5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++) checkOutput("t2_order", grant_log[i], order[i]);
        checkOutput("t2_release", rel_seen, 4);
        flush(12);

        // early drop on counter 1 of the third period
        do_reset();
        set_cfg(0, 4, 1);
        for (int k = 0; k <= 19; k++) applyStimulus((k < 11) ? 4'b0001 : 4'b0000, 1'b1);
        checkOutput("t3_pulses", pd_seen, 3);
        checkOutput("t3_release", rel_seen, 1);
        checkOutput("t3_busy", busy, 0);

        // sanitising, then a config change during RUN
        do_reset();
        set_cfg(0, 0, 7);
        applyStimulus(4'b0001, 1'b1);
        checkOutput("t4_total_zero", total_cycles, 1);
        checkOutput("t4_high_zero", high_cycles, 1);
        flush(4);
        set_cfg(1, 6, 9);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("t4_grant", grant, 4'b0010);
        checkOutput("t4_total", total_cycles, 6);
        checkOutput("t4_high", high_cycles, 6);
        for (int k = 0; k < 3; k++) applyStimulus(4'b0010, 1'b1);
        set_cfg(1, 3, 1);
        for (int k = 0; k < 3; k++) applyStimulus(4'b0010, 1'b1);
        checkOutput("t6_total_held", total_cycles, 6);
        checkOutput("t6_high_held", high_cycles, 6);
        flush(10);
        applyStimulus(4'b0010, 1'b1);
        checkOutput("t6_total_new", total_cycles, 3);
        checkOutput("t6_high_new", high_cycles, 1);
        flush(8);

        // reset in the middle of requester 2's lease
        do_reset();
        set_cfg(2, 3, 2);
        for (int k = 0; k < 5; k++) applyStimulus(4'b0100, 1'b1);
        applyStimulus(4'b0110, 1'b0);
        checkOutput("t5_grant_rst", grant, 0);
        checkOutput("t5_busy_rst", busy, 0);
        applyStimulus(4'b0110, 1'b1);
        checkOutput("t5_grant_after", grant, 4'b0010);
        flush(8);

        // random traffic
        r = '0;
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 7) == 0)
                set_cfg($urandom_range(0, NREQ - 1), $urandom_range(0, 6), $urandom_range(0, 8));
            for (int i = 0; i < NREQ; i++)
                if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
            applyStimulus(r, ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
